aria_sl_seq: RTL and testbench
==============================

// Module: aria_sl_seq
// PURPOSE
//  Iterative ARIA substitution layer (SL) on one 128-bit round state; feeds the
//  diffusion layer. Applies type-1 (odd round: S1,S2,S1^-1,S2^-1 per 4-byte group)
//  or type-2 (even round: S1^-1,S2^-1,S1,S2) using the aria_lt_s1/s2/s1i/s2i
//  S-box cells. Processes WPC 32-bit words per cycle.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  WPC  1  32-bit words substituted per cycle; legal 1,2,4 (4 S-box sets per word)
// PORTS
//  clk           in   1    clock, rising edge
//  rst           in   1    asynchronous reset, active-high
//  sl_in_valid   in   1    input state valid
//  sl_in_ready   out  1    block can accept state
//  sl_in_type    in   1    0 = type-1 (odd round), 1 = type-2 (even round)
//  sl_in_data    in   128  state; byte 0 = [127:120], word 0 = [127:96]
//  sl_out_valid  out  1    result valid
//  sl_out_ready  in   1    downstream accepts result
//  sl_out_data   out  128  substituted state
//  sl_clr        in   1    sync clear (only with ARIA_SL_CLR_EN)
// BEHAVIOUR
//  - Reset: FSM=IDLE, word counter=0, sl_in_ready=1, sl_out_valid=0, sl_out_data=0,
//    internal state/type regs=0.
//  - N = 4/WPC busy cycles. FSM states IDLE, BUSY, DONE.
//  - IDLE: sl_in_ready=1. sl_in_valid=1 -> capture data+type, cnt=0, go BUSY.
//  - BUSY: sl_in_ready=0. Each cycle substitute words cnt*WPC..cnt*WPC+WPC-1 and
//    write into the same positions of sl_out_data; cnt++. On cnt==N-1 go DONE.
//  - DONE: sl_out_valid=1; sl_out_data stable until accepted.
//    sl_out_ready=1 -> sl_out_valid drops next cycle.
//    If also sl_in_valid=1: capture new state, go BUSY directly (no IDLE bubble).
//    Otherwise go IDLE.
//  - sl_in_ready = (state==IDLE) | (state==DONE & sl_out_ready).
//  - Latency: sl_out_valid high exactly N cycles after the accepting edge.
//    Throughput: one block per N+1 cycles under continuous ready.
//  - Per byte j of each word: type-1 sel = {S1,S2,S1i,S2i}[j];
//    type-2 sel = {S1i,S2i,S1,S2}[j].
//  - Type is latched at acceptance. sl_in_type/sl_in_data changes during BUSY are ignored.
//  - sl_out_ready while not DONE is ignored. No result is dropped or duplicated.
//  - sl_out_data words not yet rewritten in BUSY hold stale values.
//    They are not valid until DONE.
//  - Async rst mid-BUSY/DONE: immediate return to reset values; in-flight block discarded.
// CONFIGURATION
//  ARIA_SL_CLR_EN defined: sl_clr port present. sl_clr=1 at an edge -> FSM=IDLE,
//   cnt=0, sl_out_valid=0, sl_out_data=0; any in-flight block is discarded.
//   sl_clr has priority over a simultaneous input handshake (that input is not taken).
//  ARIA_SL_CLR_EN undefined: no sl_clr port; only rst aborts a block.
// TESTING
//  1 rst -> outputs in_ready=1, out_valid=0, out_data=0 while rst high and after release.
//  2 in=0, type=0, WPC=1 -> out_valid 4 cycles after accept,
//    out=0x63E2523063E2523063E2523063E25230.
//  3 in=0, type=1 -> out=0x523063E2523063E2523063E2523063E2.
//    Repeat with WPC=4: latency 1 cycle.
//  4 out_ready=0 for 10 cycles in DONE -> out_valid/out_data held, in_ready=0.
//    Then out_ready=1 with in_valid=1 -> new block accepted same edge, no IDLE cycle.
//  5 Random states, both types, random in_valid/out_ready -> matches byte-wise
//    golden S-box model; results in order, none lost or duplicated.
//  6 rst (and sl_clr when ARIA_SL_CLR_EN) asserted in BUSY cycle 2
//    -> IDLE, out_valid=0, out_data=0; next block is correct.

Source files
------------

// File: rtl/aria_sl_seq.sv
// aria_sl_seq: iterative ARIA substitution layer, WPC 32-bit words per cycle.
// Define ARIA_SL_CLR_EN to add the synchronous sl_clr abort port.
module aria_sl_seq #(
  parameter int WPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sl_in_valid,
  output logic         sl_in_ready,
  input  logic         sl_in_type,
  input  logic [127:0] sl_in_data,
  output logic         sl_out_valid,
  input  logic         sl_out_ready,
  output logic [127:0] sl_out_data
`ifdef ARIA_SL_CLR_EN
  ,
  input  logic         sl_clr
`endif
);
  localparam int N = 4 / WPC;
  localparam logic [63:0] B = 64'hcbba8134b9ebbc7a;
  localparam logic [63:0] BI = 64'h9bda842589b1f3bb;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t st, nxt;
  logic [1:0] cnt;
  logic [127:0] data;
  logic typ, take, clr, last;
  logic [31:0] sub [WPC];
`ifdef ARIA_SL_CLR_EN
  assign clr = sl_clr;
`else
  assign clr = 1'b0;
`endif
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0;
    p = a;
    for (int i = 0; i < 8; i++) begin
      r = b[i] ? r ^ p : r;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction
  // x^254 == x^-1 in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] t, r;
    t = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction
  function automatic logic [7:0] lin(input logic [7:0] x, input logic [63:0] m);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) y[i] = ^(m[8*i +: 8] & x);
    return y;
  endfunction
  // sel: 0=S1, 1=S2, 2=S1^-1, 3=S2^-1; S2 = B*x^247 ^ E2, and 247^-1 mod 255 = 223 = -32
  function automatic logic [7:0] sbox(input logic [7:0] x, input logic [1:0] sel);
    logic [7:0] a, b;
    a = ginv(x);
    for (int i = 0; i < 3; i++) a = gmul(a, a);
    b = ginv(lin(x ^ 8'he2, BI));
    for (int i = 0; i < 5; i++) b = gmul(b, b);
    return sel == 2'd0 ? ginv(x) ^ rl(ginv(x), 1) ^ rl(ginv(x), 2) ^ rl(ginv(x), 3) ^ rl(ginv(x), 4) ^ 8'h63 :
           sel == 2'd1 ? lin(a, B) ^ 8'he2 :
           sel == 2'd2 ? ginv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05) : b;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w, input logic t);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = sbox(w[31-8*j -: 8], 2'(j) ^ {t, 1'b0});
    return r;
  endfunction
  always_comb begin
    for (int w = 0; w < WPC; w++) sub[w] = sub_word(data[127 - 32*(int'(cnt)*WPC + w) -: 32], typ);
  end
  always_comb begin
    last = cnt == 2'(N - 1);
    sl_in_ready = st == IDLE || (st == DONE && sl_out_ready);
    sl_out_valid = st == DONE;
    take = sl_in_valid && sl_in_ready && !clr;
    nxt = st;
    if (clr) nxt = IDLE;
    else if (take) nxt = BUSY;
    else if (st == BUSY && last) nxt = DONE;
    else if (st == DONE && sl_out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      data <= '0;
      typ <= 1'b0;
      sl_out_data <= '0;
    end else if (clr) begin
      cnt <= '0;
      sl_out_data <= '0;
    end else if (take) begin
      cnt <= '0;
      data <= sl_in_data;
      typ <= sl_in_type;
    end else if (st == BUSY) begin
      cnt <= cnt + 2'd1;
      for (int w = 0; w < WPC; w++) sl_out_data[127 - 32*(int'(cnt)*WPC + w) -: 32] <= sub[w];
    end
endmodule

// File: tb/tb_aria_sl_seq.sv
// tb_aria_sl_seq: runs WPC=1 and WPC=4 instances side by side against a table-driven S-box model.
module tb_aria_sl_seq;
  logic clk = 0, rst = 0, in_valid = 0, in_type = 0, out_ready = 0, clr = 0;
  logic [127:0] in_data = '0;
  logic rdy1, rdy4, ov1, ov4;
  logic [127:0] od1, od4;
  logic [7:0] sb [4][256];
  logic [7:0] bm [8] = '{8'h7a, 8'hbc, 8'heb, 8'hb9, 8'h34, 8'h81, 8'hba, 8'hcb};
  logic [127:0] q1[$], q4[$];
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  aria_sl_seq #(.WPC(1)) u1 (
    .clk(clk), .rst(rst), .sl_in_valid(in_valid), .sl_in_ready(rdy1), .sl_in_type(in_type),
    .sl_in_data(in_data), .sl_out_valid(ov1), .sl_out_ready(out_ready), .sl_out_data(od1)
`ifdef ARIA_SL_CLR_EN
    , .sl_clr(clr)
`endif
  );
  aria_sl_seq #(.WPC(4)) u4 (
    .clk(clk), .rst(rst), .sl_in_valid(in_valid), .sl_in_ready(rdy4), .sl_in_type(in_type),
    .sl_in_data(in_data), .sl_out_valid(ov4), .sl_out_ready(out_ready), .sl_out_data(od4)
`ifdef ARIA_SL_CLR_EN
    , .sl_clr(clr)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
    return p[7:0];
  endfunction
  function automatic logic [127:0] model(input logic [127:0] d, input logic t);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sb[(k % 4 + (t ? 2 : 0)) % 4][d[127-8*k -: 8]];
    return r;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) begin
    if (rst || clr) begin
      q1.delete();
      q4.delete();
    end else begin
      if (ov1 && out_ready) chk("u1_result", od1, q1.size() != 0 ? q1.pop_front() : 128'bx);
      if (ov4 && out_ready) chk("u4_result", od4, q4.size() != 0 ? q4.pop_front() : 128'bx);
      if (in_valid && rdy1) q1.push_back(model(in_data, in_type));
      if (in_valid && rdy4) q4.push_back(model(in_data, in_type));
    end
  end
  task automatic drain(input string tag);
    in_valid = 0;
    out_ready = 1;
    for (int k = 0; k < 40 && (q1.size() != 0 || q4.size() != 0 || !rdy1 || !rdy4); k++) tick();
    chk({tag, "_q1_left"}, 128'(q1.size()), 0);
    chk({tag, "_q4_left"}, 128'(q4.size()), 0);
    chk({tag, "_idle"}, {rdy1, rdy4, ov1, ov4}, 4'b1100);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [7:0] inv, p, a;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) a[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      sb[0][x] = a ^ 8'h63;
      p = 8'h01;
      for (int k = 0; k < 247; k++) p = gm(p, 8'(x));
      for (int i = 0; i < 8; i++) a[i] = ^(bm[i] & p);
      sb[1][x] = a ^ 8'he2;
    end
    for (int x = 0; x < 256; x++) begin
      sb[2][sb[0][x]] = 8'(x);
      sb[3][sb[1][x]] = 8'(x);
    end
    #1 rst = 1;
    #1;
    chk("rst_rdy", {rdy1, rdy4}, 2'b11);
    chk("rst_ov", {ov1, ov4}, 2'b00);
    chk("rst_od1", od1, 0);
    chk("rst_od4", od4, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
    chk("post_rst", {rdy1, rdy4, ov1, ov4}, 4'b1100);
    chk("post_rst_od", od1 | od4, 0);
    in_valid = 1;
    in_data = 0;
    in_type = 0;
    tick();
    in_valid = 0;
    chk("lat0", {ov1, ov4}, 2'b00);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("lat%0d", k), {ov1, ov4}, {k == 4, 1'b1});
    end
    chk("t1_zero_u1", od1, {4{32'h63e25230}});
    chk("t1_zero_u4", od4, {4{32'h63e25230}});
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_flags", {ov1, ov4, rdy1, rdy4}, 4'b1100);
      chk("hold_od", od1 ^ od4, 0);
    end
    chk("hold_od1", od1, {4{32'h63e25230}});
    in_valid = 1;
    in_type = 1;
    out_ready = 1;
    #1 chk("rdy_done", {rdy1, rdy4}, 2'b11);
    tick();
    in_valid = 0;
    out_ready = 0;
    chk("no_bubble", {ov1, ov4, rdy1, rdy4}, 4'b0000);
    repeat (4) tick();
    chk("t2_zero_u1", od1, {4{32'h523063e2}});
    chk("t2_zero_u4", od4, {4{32'h523063e2}});
    drain("dir");
    for (int c = 0; c < 800; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_type = 1'($urandom);
      in_data = rnd128();
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain("rand");
    in_valid = 1;
    in_type = 1'($urandom);
    in_data = rnd128();
    out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    #1;
    chk("rst_busy_flags", {rdy1, rdy4, ov1, ov4}, 4'b1100);
    chk("rst_busy_od1", od1, 0);
    chk("rst_busy_od4", od4, 0);
    @(posedge clk);
    #1 rst = 0;
    in_valid = 1;
    in_type = 1'($urandom);
    in_data = rnd128();
    tick();
    drain("after_rst");
`ifdef ARIA_SL_CLR_EN
    in_valid = 1;
    in_type = 1'($urandom);
    in_data = rnd128();
    out_ready = 0;
    tick();
    in_valid = 0;
    tick();
    clr = 1;
    in_valid = 1;
    tick();
    clr = 0;
    in_valid = 0;
    chk("clr_flags", {rdy1, rdy4, ov1, ov4}, 4'b1100);
    chk("clr_od", od1 | od4, 0);
    in_valid = 1;
    in_data = rnd128();
    tick();
    drain("after_clr");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
